// File: rtl/nts_rx_dispatch_fifo.sv
// ----------------------------------------------------------------------------
// nts_rx_dispatch_fifo - packet FIFO committing only complete good frames,
// presented one frame at a time through a first-word-fall-through read port.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module nts_rx_dispatch_fifo #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        i_clk,
  input  logic        i_areset_n,
  input  logic        i_wr_valid,
  input  logic        i_wr_sof,
  input  logic        i_wr_eof,
  input  logic        i_wr_bad,
  input  logic [63:0] i_wr_data,
  output logic        o_packet_available,
  input  logic        i_packet_read,
  output logic        o_fifo_empty,
  input  logic        i_fifo_rd_en,
  output logic [63:0] o_fifo_rd_data,
  output logic [31:0] o_frames_dropped
);

  localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {WR_IDLE, WR_RECV, WR_DISCARD} wr_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_OFFER, RD_READ} rd_state_t;

  wr_state_t r_wr_state, w_wr_state_nxt;
  rd_state_t r_rd_state, w_rd_state_nxt;

  logic [ADDR_WIDTH:0]   r_wr_ptr, r_commit_ptr, r_rd_ptr;
  logic [ADDR_WIDTH:0]   w_wr_ptr_nxt, w_commit_ptr_nxt, w_rd_ptr_nxt;
  logic [ADDR_WIDTH:0]   r_committed;
  logic                  w_mem_we, w_mem_wtag;
  logic [ADDR_WIDTH-1:0] w_mem_waddr;
  logic                  w_commit, w_accept, w_pop;
  logic                  w_full_c, w_full_w;
  logic [1:0]            w_drop_inc;
  logic [32:0]           w_drop_sum;
  logic [64:0]           r_rd_q;
  logic [31:0]           r_dropped;
  logic [64:0]           r_mem [0:(1<<ADDR_WIDTH)-1];

  assign w_accept     = (r_rd_state == RD_OFFER) && i_packet_read;
  assign w_pop        = (r_rd_state == RD_READ) && i_fifo_rd_en;
  assign w_rd_ptr_nxt = r_rd_ptr + (ADDR_WIDTH + 1)'(w_pop);

  // Fill level uses the post-pop read pointer so a same-cycle pop frees a slot.
  // A sof always restarts from commit_ptr, so it is judged against that base.
  assign w_full_c = (r_commit_ptr - w_rd_ptr_nxt) == DEPTH;
  assign w_full_w = (r_wr_ptr - w_rd_ptr_nxt) == DEPTH;

  always_comb begin
    w_wr_state_nxt   = r_wr_state;
    w_wr_ptr_nxt     = r_wr_ptr;
    w_commit_ptr_nxt = r_commit_ptr;
    w_mem_we         = 1'b0;
    w_mem_waddr      = r_wr_ptr[ADDR_WIDTH-1:0];
    w_mem_wtag       = 1'b0;
    w_commit         = 1'b0;
    w_drop_inc       = 2'd0;
    if (i_wr_valid) begin
      if (i_wr_sof) begin
        if (r_wr_state == WR_RECV) w_drop_inc = 2'd1;
        w_wr_ptr_nxt = r_commit_ptr;
        if (i_wr_eof && i_wr_bad) begin
          w_drop_inc     = w_drop_inc + 2'd1;
          w_wr_state_nxt = WR_IDLE;
        end else if (w_full_c) begin
          w_drop_inc     = w_drop_inc + 2'd1;
          w_wr_state_nxt = i_wr_eof ? WR_IDLE : WR_DISCARD;
        end else begin
          w_mem_we     = 1'b1;
          w_mem_waddr  = r_commit_ptr[ADDR_WIDTH-1:0];
          w_mem_wtag   = i_wr_eof;
          w_wr_ptr_nxt = r_commit_ptr + PTR_ONE;
          if (i_wr_eof) begin
            w_commit         = 1'b1;
            w_commit_ptr_nxt = r_commit_ptr + PTR_ONE;
            w_wr_state_nxt   = WR_IDLE;
          end else begin
            w_wr_state_nxt = WR_RECV;
          end
        end
      end else if (r_wr_state == WR_RECV) begin
        if (i_wr_eof && i_wr_bad) begin
          w_drop_inc     = 2'd1;
          w_wr_ptr_nxt   = r_commit_ptr;
          w_wr_state_nxt = WR_IDLE;
        end else if (w_full_w) begin
          w_drop_inc     = 2'd1;
          w_wr_ptr_nxt   = r_commit_ptr;
          w_wr_state_nxt = i_wr_eof ? WR_IDLE : WR_DISCARD;
        end else begin
          w_mem_we     = 1'b1;
          w_mem_wtag   = i_wr_eof;
          w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
          if (i_wr_eof) begin
            w_commit         = 1'b1;
            w_commit_ptr_nxt = r_wr_ptr + PTR_ONE;
            w_wr_state_nxt   = WR_IDLE;
          end
        end
      end else if (r_wr_state == WR_DISCARD && i_wr_eof) begin
        w_wr_state_nxt = WR_IDLE;
      end
    end
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    case (r_rd_state)
      RD_IDLE:  if (r_committed != '0 || w_commit) w_rd_state_nxt = RD_OFFER;
      RD_OFFER: if (i_packet_read) w_rd_state_nxt = RD_READ;
      RD_READ:  if (w_pop && r_rd_q[64]) w_rd_state_nxt = RD_IDLE;
      default:  w_rd_state_nxt = RD_IDLE;
    endcase
  end

  assign w_drop_sum = {1'b0, r_dropped} + 33'(w_drop_inc);

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_wr_state   <= WR_IDLE;
      r_rd_state   <= RD_IDLE;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_committed  <= '0;
      r_dropped    <= '0;
      r_rd_q       <= '0;
    end else begin
      r_wr_state   <= w_wr_state_nxt;
      r_rd_state   <= w_rd_state_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_commit_ptr <= w_commit_ptr_nxt;
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_committed  <= r_committed + (ADDR_WIDTH + 1)'(w_commit)
                                  - (ADDR_WIDTH + 1)'(w_accept);
      r_dropped    <= w_drop_sum[32] ? 32'hFFFF_FFFF : w_drop_sum[31:0];
      // Prefetch the word the read pointer will point at next cycle.
      r_rd_q       <= r_mem[w_rd_ptr_nxt[ADDR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= {w_mem_wtag, i_wr_data};
  end

  assign o_packet_available = (r_rd_state == RD_OFFER);
  assign o_fifo_empty       = (r_rd_state != RD_READ);
  assign o_fifo_rd_data     = r_rd_q[63:0];
  assign o_frames_dropped   = r_dropped;

endmodule

`default_nettype wire

// File: tb/tb_nts_rx_dispatch_fifo.sv
// ----------------------------------------------------------------------------
// tb_nts_rx_dispatch_fifo - directed self-checking bench, depth-8 instance.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_nts_rx_dispatch_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_wr_valid, i_wr_sof, i_wr_eof, i_wr_bad;
  logic [63:0] i_wr_data;
  logic        o_packet_available, i_packet_read, o_fifo_empty, i_fifo_rd_en;
  logic [63:0] o_fifo_rd_data;
  logic [31:0] o_frames_dropped;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nts_rx_dispatch_fifo #(.ADDR_WIDTH(3)) dut (
    .i_clk              (clk),
    .i_areset_n         (rst_n),
    .i_wr_valid         (i_wr_valid),
    .i_wr_sof           (i_wr_sof),
    .i_wr_eof           (i_wr_eof),
    .i_wr_bad           (i_wr_bad),
    .i_wr_data          (i_wr_data),
    .o_packet_available (o_packet_available),
    .i_packet_read      (i_packet_read),
    .o_fifo_empty       (o_fifo_empty),
    .i_fifo_rd_en       (i_fifo_rd_en),
    .o_fifo_rd_data     (o_fifo_rd_data),
    .o_frames_dropped   (o_frames_dropped)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_word(input logic s, input logic e, input logic b, input logic [63:0] d);
    i_wr_valid = 1'b1; i_wr_sof = s; i_wr_eof = e; i_wr_bad = b; i_wr_data = d;
    tick();
  endtask

  task automatic wr_stop();
    i_wr_valid = 1'b0; i_wr_sof = 1'b0; i_wr_eof = 1'b0; i_wr_bad = 1'b0;
  endtask

  task automatic do_reset();
    wr_stop();
    i_wr_data = '0; i_packet_read = 1'b0; i_fifo_rd_en = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [63:0] pat(input int i);
    return 64'hA5A5_0000_0000_0000 + 64'(i);
  endfunction

  task automatic test_reset();
    wr_stop();
    i_wr_data = '0; i_packet_read = 1'b0; i_fifo_rd_en = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++; if (o_packet_available !== 1'b0) begin errors++; $display("FAIL reset_avail: got %b expected 0", o_packet_available); end
    checks++; if (o_fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", o_fifo_empty); end
    checks++; if (o_fifo_rd_data !== 64'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", o_fifo_rd_data); end
    checks++; if (o_frames_dropped !== 32'h0) begin errors++; $display("FAIL reset_dropped: got %0d expected 0", o_frames_dropped); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_good_frame();
    logic [63:0] w [3];
    w[0] = 64'hdeadbeef00000000; w[1] = 64'habad1deac0fef00d; w[2] = 64'h0123456789abcdef;
    do_reset();
    drive_word(1'b1, 1'b0, 1'b0, w[0]);
    drive_word(1'b0, 1'b0, 1'b0, w[1]);
    i_wr_valid = 1'b1; i_wr_eof = 1'b1; i_wr_data = w[2];
    checks++; if (o_packet_available !== 1'b0) begin errors++; $display("FAIL good_avail_early: got %b expected 0", o_packet_available); end
    tick();
    wr_stop();
    checks++; if (o_packet_available !== 1'b1) begin errors++; $display("FAIL good_avail: got %b expected 1", o_packet_available); end
    checks++; if (o_fifo_empty !== 1'b1) begin errors++; $display("FAIL good_empty_before: got %b expected 1", o_fifo_empty); end
    i_packet_read = 1'b1;
    tick();
    i_packet_read = 1'b0;
    checks++; if (o_packet_available !== 1'b0) begin errors++; $display("FAIL good_avail_after_read: got %b expected 0", o_packet_available); end
    checks++; if (o_fifo_empty !== 1'b0) begin errors++; $display("FAIL good_empty_after_read: got %b expected 0", o_fifo_empty); end
    i_fifo_rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (o_fifo_rd_data !== w[i]) begin errors++; $display("FAIL good_word%0d: got %h expected %h", i, o_fifo_rd_data, w[i]); end
      tick();
    end
    i_fifo_rd_en = 1'b0;
    checks++; if (o_fifo_empty !== 1'b1) begin errors++; $display("FAIL good_empty_end: got %b expected 1", o_fifo_empty); end
    checks++; if (o_frames_dropped !== 32'd0) begin errors++; $display("FAIL good_dropped: got %0d expected 0", o_frames_dropped); end
  endtask

  task automatic test_bad_then_good();
    do_reset();
    drive_word(1'b1, 1'b0, 1'b0, 64'h1111_1111_1111_1111);
    drive_word(1'b0, 1'b1, 1'b1, 64'h2222_2222_2222_2222);
    drive_word(1'b1, 1'b1, 1'b0, 64'hB0B0_B0B0_B0B0_B0B0);
    wr_stop();
    checks++; if (o_frames_dropped !== 32'd1) begin errors++; $display("FAIL bad_dropped: got %0d expected 1", o_frames_dropped); end
    checks++; if (o_packet_available !== 1'b1) begin errors++; $display("FAIL bad_avail: got %b expected 1", o_packet_available); end
    i_packet_read = 1'b1;
    tick();
    i_packet_read = 1'b0;
    checks++; if (o_fifo_rd_data !== 64'hB0B0_B0B0_B0B0_B0B0) begin errors++; $display("FAIL bad_word: got %h expected b0b0b0b0b0b0b0b0", o_fifo_rd_data); end
    i_fifo_rd_en = 1'b1;
    tick();
    i_fifo_rd_en = 1'b0;
    checks++; if (o_fifo_empty !== 1'b1) begin errors++; $display("FAIL bad_empty: got %b expected 1", o_fifo_empty); end
    tick(); tick(); tick();
    checks++; if (o_packet_available !== 1'b0) begin errors++; $display("FAIL bad_second_offer: got %b expected 0", o_packet_available); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) drive_word(i == 0, i == 8, 1'b0, pat(100 + i));
    wr_stop();
    checks++; if (o_frames_dropped !== 32'd1) begin errors++; $display("FAIL ovf_dropped: got %0d expected 1", o_frames_dropped); end
    tick(); tick();
    checks++; if (o_packet_available !== 1'b0) begin errors++; $display("FAIL ovf_no_offer: got %b expected 0", o_packet_available); end
    for (int i = 0; i < 8; i++) drive_word(i == 0, i == 7, 1'b0, pat(200 + i));
    wr_stop();
    checks++; if (o_packet_available !== 1'b1) begin errors++; $display("FAIL ovf_full_avail: got %b expected 1", o_packet_available); end
    i_packet_read = 1'b1;
    tick();
    i_packet_read = 1'b0;
    i_fifo_rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (o_fifo_rd_data !== pat(200 + i)) begin errors++; $display("FAIL ovf_word%0d: got %h expected %h", i, o_fifo_rd_data, pat(200 + i)); end
      tick();
    end
    i_fifo_rd_en = 1'b0;
    checks++; if (o_fifo_empty !== 1'b1) begin errors++; $display("FAIL ovf_empty: got %b expected 1", o_fifo_empty); end
    checks++; if (o_frames_dropped !== 32'd1) begin errors++; $display("FAIL ovf_dropped_end: got %0d expected 1", o_frames_dropped); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    fork
      begin
        for (int f = 0; f < 100; f++) begin
          for (int w = 0; w < 5; w++) drive_word(w == 0, w == 4, 1'b0, pat(f * 5 + w));
          wr_stop();
          tick(); tick(); tick();
        end
      end
      begin
        for (int f = 0; f < 100; f++) begin
          bit got;
          got = 1'b0;
          for (int t = 0; t < 100; t++) begin
            if (o_packet_available === 1'b1) begin got = 1'b1; break; end
            tick();
          end
          checks++;
          if (!got) begin errors++; $display("FAIL wrap_timeout frame %0d: got no offer expected offer", f); break; end
          i_packet_read = 1'b1;
          tick();
          i_packet_read = 1'b0;
          for (int w = 0; w < 5; w++) begin
            checks++; if (o_fifo_rd_data !== pat(f * 5 + w)) begin errors++; $display("FAIL wrap_word f%0d w%0d: got %h expected %h", f, w, o_fifo_rd_data, pat(f * 5 + w)); end
            i_fifo_rd_en = 1'b1;
            tick();
          end
          i_fifo_rd_en = 1'b0;
          checks++; if (o_fifo_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty f%0d: got %b expected 1", f, o_fifo_empty); end
        end
      end
    join
    checks++; if (o_frames_dropped !== 32'd0) begin errors++; $display("FAIL wrap_dropped: got %0d expected 0", o_frames_dropped); end
  endtask

  task automatic test_abort();
    do_reset();
    drive_word(1'b1, 1'b0, 1'b0, 64'hAAAA_0000_0000_0001);
    drive_word(1'b0, 1'b0, 1'b0, 64'hAAAA_0000_0000_0002);
    drive_word(1'b1, 1'b0, 1'b0, 64'hCCCC_0000_0000_0001);
    drive_word(1'b0, 1'b1, 1'b0, 64'hCCCC_0000_0000_0002);
    wr_stop();
    checks++; if (o_frames_dropped !== 32'd1) begin errors++; $display("FAIL abort_dropped: got %0d expected 1", o_frames_dropped); end
    checks++; if (o_packet_available !== 1'b1) begin errors++; $display("FAIL abort_avail: got %b expected 1", o_packet_available); end
    i_packet_read = 1'b1;
    tick();
    i_packet_read = 1'b0;
    checks++; if (o_fifo_rd_data !== 64'hCCCC_0000_0000_0001) begin errors++; $display("FAIL abort_word0: got %h expected cccc000000000001", o_fifo_rd_data); end
    i_fifo_rd_en = 1'b1;
    tick();
    checks++; if (o_fifo_rd_data !== 64'hCCCC_0000_0000_0002) begin errors++; $display("FAIL abort_word1: got %h expected cccc000000000002", o_fifo_rd_data); end
    tick();
    i_fifo_rd_en = 1'b0;
    checks++; if (o_fifo_empty !== 1'b1) begin errors++; $display("FAIL abort_empty: got %b expected 1", o_fifo_empty); end
    tick(); tick(); tick();
    checks++; if (o_packet_available !== 1'b0) begin errors++; $display("FAIL abort_second_offer: got %b expected 0", o_packet_available); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    drive_word(1'b1, 1'b0, 1'b0, 64'hDDDD_0000_0000_0001);
    drive_word(1'b0, 1'b0, 1'b0, 64'hDDDD_0000_0000_0002);
    wr_stop();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive_word(1'b0, 1'b0, 1'b0, 64'hDDDD_0000_0000_0003);
    drive_word(1'b0, 1'b1, 1'b0, 64'hDDDD_0000_0000_0004);
    drive_word(1'b1, 1'b0, 1'b0, 64'hEEEE_0000_0000_0001);
    drive_word(1'b0, 1'b1, 1'b0, 64'hEEEE_0000_0000_0002);
    wr_stop();
    checks++; if (o_frames_dropped !== 32'd0) begin errors++; $display("FAIL rstmid_dropped: got %0d expected 0", o_frames_dropped); end
    checks++; if (o_packet_available !== 1'b1) begin errors++; $display("FAIL rstmid_avail: got %b expected 1", o_packet_available); end
    i_packet_read = 1'b1;
    tick();
    i_packet_read = 1'b0;
    checks++; if (o_fifo_rd_data !== 64'hEEEE_0000_0000_0001) begin errors++; $display("FAIL rstmid_word0: got %h expected eeee000000000001", o_fifo_rd_data); end
    i_fifo_rd_en = 1'b1;
    tick();
    checks++; if (o_fifo_rd_data !== 64'hEEEE_0000_0000_0002) begin errors++; $display("FAIL rstmid_word1: got %h expected eeee000000000002", o_fifo_rd_data); end
    tick();
    i_fifo_rd_en = 1'b0;
    checks++; if (o_fifo_empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty: got %b expected 1", o_fifo_empty); end
    tick(); tick(); tick();
    checks++; if (o_packet_available !== 1'b0) begin errors++; $display("FAIL rstmid_second_offer: got %b expected 0", o_packet_available); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_then_good();
    test_overflow();
    test_back_to_back();
    test_abort();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
